// File: rtl/traffic_ctl_nway.sv
// N-approach actuated traffic-light controller: round-robin service of latched demand,
// min/max green extension, all-red clearance and flashing-yellow mode.
module traffic_ctl_nway #(
  parameter int N_WAY       = 2,
  parameter int PRE_W       = 4,
  parameter int T_W         = 4,
  parameter int GRN_MIN     = 6,
  parameter int GRN_MAX     = 12,
  parameter int YLW_TIME    = 3,
  parameter int ALLRED_TIME = 1,
  localparam int A_W        = (N_WAY > 1) ? $clog2(N_WAY) : 1
) (
  input  logic             CK,
  input  logic             CLR_N,
  input  logic             TEST,
  input  logic             FLASH,
  input  logic [N_WAY-1:0] FM,
  output logic [N_WAY-1:0] GRN,
  output logic [N_WAY-1:0] YLW,
  output logic [N_WAY-1:0] RED,
  output logic [A_W-1:0]   ACTIVE,
  output logic             TICK,
  output logic [1:0]       DBG_STATE,
  output logic [N_WAY-1:0] DBG_DEM
);

  localparam logic [1:0] S_ALLRED = 2'd0;
  localparam logic [1:0] S_GREEN  = 2'd1;
  localparam logic [1:0] S_YELLOW = 2'd2;
  localparam logic [1:0] S_FLASH  = 2'd3;

  localparam logic [T_W-1:0] T_SAT   = '1;
  localparam logic [T_W-1:0] T_GMIN  = T_W'(GRN_MIN - 1);
  localparam logic [T_W-1:0] T_GMAX  = T_W'(GRN_MAX - 1);
  localparam logic [T_W-1:0] T_YLW   = T_W'(YLW_TIME - 1);
  localparam logic [T_W-1:0] T_ARED  = T_W'(ALLRED_TIME - 1);

  logic [1:0]       r_state, w_state_nxt;
  logic [T_W-1:0]   r_timer, w_timer_nxt, w_timer_inc;
  logic [PRE_W-1:0] r_pre;
  logic [A_W-1:0]   r_active, w_active_nxt;
  logic [A_W-1:0]   r_next, w_next_nxt, w_rr_next;
  logic [N_WAY-1:0] r_dem, w_dem_nxt;
  logic [N_WAY-1:0] w_act_oh, w_green_oh;
  logic             r_phase, w_phase_nxt;
  logic             w_tick, w_fm_act, w_other_dem, w_enter_green;
  int               w_best, w_dist;

  // In TEST the prescaler is parked and every cycle is a tick.
  assign w_tick = TEST | (&r_pre);

  always_ff @(posedge CK or negedge CLR_N) begin
    if (!CLR_N) begin
      r_pre <= '0;
    end else if (TEST) begin
      r_pre <= '0;
    end else begin
      r_pre <= r_pre + 1'b1;
    end
  end

  always_comb begin
    w_act_oh = '0;
    w_fm_act = 1'b0;
    for (int j = 0; j < N_WAY; j++) begin
      if (r_active == A_W'(j)) begin
        w_act_oh[j] = 1'b1;
        w_fm_act    = FM[j];
      end
    end
  end

  assign w_other_dem = |(r_dem & ~w_act_oh);
  assign w_green_oh  = (r_state == S_GREEN) ? w_act_oh : '0;

  // Round-robin pick: smallest forward distance from ACTIVE+1 among demanding approaches.
  always_comb begin
    w_rr_next = '0;
    w_best    = N_WAY;
    w_dist    = 0;
    for (int j = 0; j < N_WAY; j++) begin
      if (r_dem[j]) begin
        w_dist = (j + 2 * N_WAY - 1 - int'(r_active)) % N_WAY;
        if (w_dist < w_best) begin
          w_best    = w_dist;
          w_rr_next = A_W'(j);
        end
      end
    end
  end

  assign w_timer_inc = (r_timer == T_SAT) ? r_timer : r_timer + 1'b1;

  always_comb begin
    w_state_nxt   = r_state;
    w_timer_nxt   = r_timer;
    w_active_nxt  = r_active;
    w_next_nxt    = r_next;
    w_phase_nxt   = r_phase;
    w_enter_green = 1'b0;
    if (w_tick) begin
      w_timer_nxt = w_timer_inc;
      case (r_state)
        S_ALLRED: begin
          if (FLASH) begin
            w_state_nxt = S_FLASH;
            w_timer_nxt = '0;
            w_phase_nxt = 1'b1;
          end else if (r_timer == T_ARED) begin
            w_state_nxt   = S_GREEN;
            w_timer_nxt   = '0;
            w_active_nxt  = r_next;
            w_enter_green = 1'b1;
          end
        end
        S_GREEN: begin
          if (FLASH) begin
            w_state_nxt = S_YELLOW;
            w_timer_nxt = '0;
            w_next_nxt  = '0;
          end else if ((r_timer >= T_GMIN) && w_other_dem &&
                       (!w_fm_act || (r_timer >= T_GMAX))) begin
            w_state_nxt = S_YELLOW;
            w_timer_nxt = '0;
            w_next_nxt  = w_rr_next;
          end
        end
        S_YELLOW: begin
          if (r_timer == T_YLW) begin
            w_timer_nxt = '0;
            if (FLASH) begin
              w_state_nxt = S_FLASH;
              w_phase_nxt = 1'b1;
            end else begin
              w_state_nxt = S_ALLRED;
            end
          end
        end
        default: begin
          if (!FLASH) begin
            w_state_nxt = S_ALLRED;
            w_timer_nxt = '0;
            w_next_nxt  = '0;
            w_phase_nxt = 1'b0;
          end else begin
            w_phase_nxt = ~r_phase;
          end
        end
      endcase
    end
  end

  // Entering green clears that approach's demand even if its sensor is active this cycle.
  always_comb begin
    w_dem_nxt = r_dem | (FM & ~w_green_oh);
    if (r_state == S_FLASH) begin
      w_dem_nxt = '0;
    end else if (w_enter_green) begin
      for (int j = 0; j < N_WAY; j++) begin
        if (r_next == A_W'(j)) begin
          w_dem_nxt[j] = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge CK or negedge CLR_N) begin
    if (!CLR_N) begin
      r_state  <= S_ALLRED;
      r_timer  <= '0;
      r_active <= '0;
      r_next   <= '0;
      r_dem    <= '0;
      r_phase  <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_timer  <= w_timer_nxt;
      r_active <= w_active_nxt;
      r_next   <= w_next_nxt;
      r_dem    <= w_dem_nxt;
      r_phase  <= w_phase_nxt;
    end
  end

  always_comb begin
    GRN = '0;
    YLW = '0;
    RED = '1;
    case (r_state)
      S_GREEN: begin
        GRN = w_act_oh;
        RED = ~w_act_oh;
      end
      S_YELLOW: begin
        YLW = w_act_oh;
        RED = ~w_act_oh;
      end
      S_FLASH: begin
        YLW = {N_WAY{r_phase}};
        RED = '0;
      end
      default: begin
        RED = '1;
      end
    endcase
  end

  assign TICK      = w_tick & CLR_N;
  assign ACTIVE    = r_active;
  assign DBG_STATE = r_state;
  assign DBG_DEM   = r_dem;

endmodule

// File: tb/tb_traffic_ctl_nway.sv
// Directed bench for traffic_ctl_nway: a 2-way instance for timing/flash/reset cases and
// a 3-way instance for round-robin order; expected lamp words are queued and popped.
module tb_traffic_ctl_nway;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       a_clr_n, a_test, a_flash;
  logic [1:0] a_fm, a_grn, a_ylw, a_red, a_state, a_dem;
  logic [0:0] a_act;
  logic       a_tick;

  logic       b_clr_n, b_test, b_flash;
  logic [2:0] b_fm, b_grn, b_ylw, b_red, b_dem;
  logic [1:0] b_act, b_state;
  logic       b_tick;

  traffic_ctl_nway #(.N_WAY(2)) u_a (
    .CK(clk), .CLR_N(a_clr_n), .TEST(a_test), .FLASH(a_flash), .FM(a_fm),
    .GRN(a_grn), .YLW(a_ylw), .RED(a_red), .ACTIVE(a_act), .TICK(a_tick),
    .DBG_STATE(a_state), .DBG_DEM(a_dem)
  );

  traffic_ctl_nway #(.N_WAY(3)) u_b (
    .CK(clk), .CLR_N(b_clr_n), .TEST(b_test), .FLASH(b_flash), .FM(b_fm),
    .GRN(b_grn), .YLW(b_ylw), .RED(b_red), .ACTIVE(b_act), .TICK(b_tick),
    .DBG_STATE(b_state), .DBG_DEM(b_dem)
  );

  logic [15:0] exp_q[$];
  string       tag_q[$];
  int          total = 0;
  int          bad   = 0;

  // Word layout: {0, tick, dem[2:0], active[1:0], grn[2:0], ylw[2:0], red[2:0]}
  function automatic logic [15:0] pack_a(input logic t, input logic [1:0] d, input logic a,
                                         input logic [1:0] g, input logic [1:0] y,
                                         input logic [1:0] r);
    return {1'b0, t, 1'b0, d, 1'b0, a, 1'b0, g, 1'b0, y, 1'b0, r};
  endfunction

  function automatic logic [15:0] pack_b(input logic t, input logic [2:0] d, input logic [1:0] a,
                                         input logic [2:0] g, input logic [2:0] y,
                                         input logic [2:0] r);
    return {1'b0, t, d, a, g, y, r};
  endfunction

  task automatic cmp(input logic [15:0] obs);
    logic [15:0] e;
    string       tg;
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $error("FAIL queue_empty obs=%h exp=none", obs);
    end else begin
      e  = exp_q.pop_front();
      tg = tag_q.pop_front();
      assert (obs === e) else begin
        bad++;
        $error("FAIL %s obs=%h exp=%h", tg, obs, e);
      end
    end
  endtask

  task automatic expa(input string tag, input logic t, input logic [1:0] d, input logic a,
                      input logic [1:0] g, input logic [1:0] y, input logic [1:0] r);
    exp_q.push_back(pack_a(t, d, a, g, y, r));
    tag_q.push_back(tag);
  endtask

  task automatic expb(input string tag, input logic t, input logic [2:0] d, input logic [1:0] a,
                      input logic [2:0] g, input logic [2:0] y, input logic [2:0] r);
    exp_q.push_back(pack_b(t, d, a, g, y, r));
    tag_q.push_back(tag);
  endtask

  task automatic sample_a();
    cmp(pack_a(a_tick, a_dem, a_act[0], a_grn, a_ylw, a_red));
  endtask

  task automatic cyc_a();
    @(posedge clk);
    #1;
    sample_a();
  endtask

  task automatic cyc_b();
    @(posedge clk);
    #1;
    cmp(pack_b(b_tick, b_dem, b_act, b_grn, b_ylw, b_red));
  endtask

  task automatic run_a(input string tag, input logic t, input logic [1:0] d, input logic a,
                       input logic [1:0] g, input logic [1:0] y, input logic [1:0] r,
                       input int n);
    repeat (n) begin
      expa(tag, t, d, a, g, y, r);
      cyc_a();
    end
  endtask

  task automatic run_b(input string tag, input logic t, input logic [2:0] d, input logic [1:0] a,
                       input logic [2:0] g, input logic [2:0] y, input logic [2:0] r,
                       input int n);
    repeat (n) begin
      expb(tag, t, d, a, g, y, r);
      cyc_b();
    end
  endtask

  task automatic reset_a();
    a_clr_n = 1'b0;
    a_fm    = '0;
    a_flash = 1'b0;
    run_a("a_reset", 1'b0, 2'b00, 1'b0, 2'b00, 2'b00, 2'b11, 2);
    a_clr_n = 1'b1;
  endtask

  initial begin
    a_clr_n = 1'b0; a_test = 1'b1; a_flash = 1'b0; a_fm = '0;
    b_clr_n = 1'b0; b_test = 1'b1; b_flash = 1'b0; b_fm = '0;

    // Release: green 0 on the first edge, then held with no competing demand.
    reset_a();
    run_a("a_idle_green", 1'b1, 2'b00, 1'b0, 2'b01, 2'b00, 2'b10, 51);

    // Minimum green then switch to approach 1.
    reset_a();
    run_a("a_g0_min", 1'b1, 2'b00, 1'b0, 2'b01, 2'b00, 2'b10, 1);
    a_fm = 2'b10;
    run_a("a_g0_dem", 1'b1, 2'b10, 1'b0, 2'b01, 2'b00, 2'b10, 1);
    a_fm = 2'b00;
    run_a("a_g0_hold", 1'b1, 2'b10, 1'b0, 2'b01, 2'b00, 2'b10, 4);
    run_a("a_y0", 1'b1, 2'b10, 1'b0, 2'b00, 2'b01, 2'b10, 3);
    run_a("a_allred", 1'b1, 2'b10, 1'b0, 2'b00, 2'b00, 2'b11, 1);
    run_a("a_g1", 1'b1, 2'b00, 1'b1, 2'b10, 2'b00, 2'b01, 2);

    // Extension: own sensor held keeps green up to the maximum.
    reset_a();
    run_a("a_ext_g0", 1'b1, 2'b00, 1'b0, 2'b01, 2'b00, 2'b10, 1);
    a_fm = 2'b11;
    run_a("a_ext_dem", 1'b1, 2'b10, 1'b0, 2'b01, 2'b00, 2'b10, 1);
    a_fm = 2'b01;
    run_a("a_ext_hold", 1'b1, 2'b10, 1'b0, 2'b01, 2'b00, 2'b10, 10);
    run_a("a_ext_y0", 1'b1, 2'b10, 1'b0, 2'b00, 2'b01, 2'b10, 1);
    a_fm = 2'b00;
    run_a("a_ext_y0b", 1'b1, 2'b10, 1'b0, 2'b00, 2'b01, 2'b10, 1);

    // Flash mode entered from green, demand suppressed, then recovery to green 0.
    reset_a();
    run_a("a_fl_g0", 1'b1, 2'b00, 1'b0, 2'b01, 2'b00, 2'b10, 1);
    a_flash = 1'b1;
    run_a("a_fl_y0", 1'b1, 2'b00, 1'b0, 2'b00, 2'b01, 2'b10, 3);
    run_a("a_fl_on", 1'b1, 2'b00, 1'b0, 2'b00, 2'b11, 2'b00, 1);
    a_fm = 2'b10;
    run_a("a_fl_off", 1'b1, 2'b00, 1'b0, 2'b00, 2'b00, 2'b00, 1);
    a_fm = 2'b00;
    run_a("a_fl_on2", 1'b1, 2'b00, 1'b0, 2'b00, 2'b11, 2'b00, 1);
    run_a("a_fl_off2", 1'b1, 2'b00, 1'b0, 2'b00, 2'b00, 2'b00, 1);
    a_flash = 1'b0;
    run_a("a_fl_allred", 1'b1, 2'b00, 1'b0, 2'b00, 2'b00, 2'b11, 1);
    run_a("a_fl_g0_back", 1'b1, 2'b00, 1'b0, 2'b01, 2'b00, 2'b10, 2);

    // Asynchronous reset in the middle of yellow.
    reset_a();
    run_a("a_ar_g0", 1'b1, 2'b00, 1'b0, 2'b01, 2'b00, 2'b10, 1);
    a_fm = 2'b10;
    run_a("a_ar_g0_dem", 1'b1, 2'b10, 1'b0, 2'b01, 2'b00, 2'b10, 1);
    a_fm = 2'b00;
    run_a("a_ar_g0_hold", 1'b1, 2'b10, 1'b0, 2'b01, 2'b00, 2'b10, 4);
    run_a("a_ar_y0", 1'b1, 2'b10, 1'b0, 2'b00, 2'b01, 2'b10, 1);
    #3;
    a_clr_n = 1'b0;
    #1;
    expa("a_async_rst", 1'b0, 2'b00, 1'b0, 2'b00, 2'b00, 2'b11);
    sample_a();

    // Prescaled operation: one tick every 16 cycles.
    a_test = 1'b0;
    reset_a();
    for (int i = 1; i <= 32; i++) begin
      if (i < 16) expa("a_pre_allred", (i == 15), 2'b00, 1'b0, 2'b00, 2'b00, 2'b11);
      else        expa("a_pre_green", (i == 31), 2'b00, 1'b0, 2'b01, 2'b00, 2'b10);
      cyc_a();
    end

    // Three-way round-robin: approach 2 then 1 request, served 1 then 2.
    run_b("b_reset", 1'b0, 3'b000, 2'd0, 3'b000, 3'b000, 3'b111, 2);
    b_clr_n = 1'b1;
    run_b("b_g0", 1'b1, 3'b000, 2'd0, 3'b001, 3'b000, 3'b110, 1);
    b_fm = 3'b100;
    run_b("b_g0_d2", 1'b1, 3'b100, 2'd0, 3'b001, 3'b000, 3'b110, 1);
    b_fm = 3'b010;
    run_b("b_g0_d21", 1'b1, 3'b110, 2'd0, 3'b001, 3'b000, 3'b110, 1);
    b_fm = 3'b000;
    run_b("b_g0_hold", 1'b1, 3'b110, 2'd0, 3'b001, 3'b000, 3'b110, 3);
    run_b("b_y0", 1'b1, 3'b110, 2'd0, 3'b000, 3'b001, 3'b110, 3);
    run_b("b_ar0", 1'b1, 3'b110, 2'd0, 3'b000, 3'b000, 3'b111, 1);
    run_b("b_g1", 1'b1, 3'b100, 2'd1, 3'b010, 3'b000, 3'b101, 6);
    run_b("b_y1", 1'b1, 3'b100, 2'd1, 3'b000, 3'b010, 3'b101, 3);
    run_b("b_ar1", 1'b1, 3'b100, 2'd1, 3'b000, 3'b000, 3'b111, 1);
    run_b("b_g2", 1'b1, 3'b000, 2'd2, 3'b100, 3'b000, 3'b011, 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
